// File: rtl/types_pkg.sv
// Shared types and helpers for the MEMORY-stage data-memory interface.
// Provides the data bus width, load/store access size, FSM state encoding,
// the latched request payload, and byte-lane helper functions.
package types_pkg;

    localparam int unsigned DATA_BUS = 32;
    localparam int unsigned BE_W     = DATA_BUS / 8;

    // Access size of a load/store; 2'b11 is not a legal size and decodes as WORD.
    typedef enum logic [1:0] {
        BYTE = 2'b00,
        HALF = 2'b01,
        WORD = 2'b10
    } byte_format;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        DONE = 2'b10
    } mem_state_t;

    // Request fields captured in IDLE and held for the whole bus transaction.
    typedef struct packed {
        logic [DATA_BUS-1:0] addr;
        logic [1:0]          off;
        logic [BE_W-1:0]     be;
        logic [DATA_BUS-1:0] wdata;
        logic                we;
        byte_format          fmt;
        logic                ext;
    } mem_req_t;

    // Byte enables for an access of size fmt at byte offset off within the word.
    function automatic logic [BE_W-1:0] be_gen(input byte_format fmt, input logic [1:0] off);
        case (fmt)
            BYTE:    return 4'b0001 << off;
            HALF:    return 4'b0011 << off;
            default: return 4'b1111;
        endcase
    endfunction

    // An access is misaligned when it would cross its natural boundary.
    function automatic logic is_misaligned(input byte_format fmt, input logic [1:0] off);
        case (fmt)
            BYTE:    return 1'b0;
            HALF:    return off[0];
            default: return |off;
        endcase
    endfunction

    // Replicate the store data so the selected lanes carry it whatever the offset.
    function automatic logic [DATA_BUS-1:0] wdata_gen(input byte_format fmt,
                                                      input logic [DATA_BUS-1:0] wd);
        case (fmt)
            BYTE:    return {4{wd[7:0]}};
            HALF:    return {2{wd[15:0]}};
            default: return wd;
        endcase
    endfunction

endpackage

// File: rtl/load_formatter.sv
// Load data formatter: picks the addressed byte/halfword from a read word and
// sign- or zero-extends it; whole words pass straight through.
// Ports:
//   rdata_i   read word from the bus
//   offset_i  byte offset of the access within the word
//   fmt_i     access size (byte_format encoding)
//   extend_i  1 = sign-extend, 0 = zero-extend
//   result_o  formatted 32-bit load value (combinational)
module load_formatter
    import types_pkg::*;
(
    input  logic [DATA_BUS-1:0] rdata_i,
    input  logic [1:0]          offset_i,
    input  logic [1:0]          fmt_i,
    input  logic                extend_i,
    output logic [DATA_BUS-1:0] result_o
);

    logic [15:0] low_half;

    // Bring the addressed lane down to bit 0; only the low halfword is ever needed.
    assign low_half = 16'(rdata_i >> {offset_i, 3'b000});

    always_comb begin
        result_o = rdata_i;
        case (byte_format'(fmt_i))
            BYTE:    result_o = {{24{extend_i & low_half[7]}},  low_half[7:0]};
            HALF:    result_o = {{16{extend_i & low_half[15]}}, low_half};
            default: result_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/memory_access_unit.sv
// MEMORY-stage data-memory interface. Converts the stage's load/store control
// into a req/ack bus transaction, stalls the pipeline until it completes, and
// returns formatted load data. Misaligned accesses are flagged without issuing;
// a bus that never acknowledges is aborted after TIMEOUT_CYCLES.
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   ValidM_i .. MemExtendM_i       MEMORY-stage instruction control and operands
//   StallM_o                       combinational stall for upstream registers
//   ReadDataM_o, MisalignM_o,      registered results, valid only in DONE
//   BusErrM_o
//   mem_req_o .. mem_wdata_o       bus request side, driven only while in REQ
//   mem_ack_i, mem_rdata_i         bus completion and read data
module memory_access_unit
    import types_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ValidM_i,
    input  logic [DATA_BUS-1:0] ALU_outM_i,
    input  logic [DATA_BUS-1:0] WriteDataM_i,
    input  logic                MemWriteM_i,
    input  logic                ResultSrcM_i,
    input  logic [1:0]          ByteSelectM_i,
    input  logic                MemExtendM_i,
    output logic                StallM_o,
    output logic [DATA_BUS-1:0] ReadDataM_o,
    output logic                MisalignM_o,
    output logic                BusErrM_o,
    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic [DATA_BUS-1:0] mem_addr_o,
    output logic [BE_W-1:0]     mem_be_o,
    output logic [DATA_BUS-1:0] mem_wdata_o,
    input  logic                mem_ack_i,
    input  logic [DATA_BUS-1:0] mem_rdata_i
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);

    mem_state_t          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    mem_req_t            req_q, req_d;
    logic [DATA_BUS-1:0] rdata_q, rdata_d;
    logic                mis_q, mis_d;
    logic                berr_q, berr_d;

    logic                access;
    logic                in_req;
    byte_format          fmt_in;
    logic [DATA_BUS-1:0] load_data;

    assign access = ValidM_i & (MemWriteM_i | ResultSrcM_i);
    assign fmt_in = byte_format'(ByteSelectM_i);
    assign in_req = (state_q == REQ);

    // Formats from the latched request so live inputs cannot disturb the result.
    load_formatter u_load_formatter (
        .rdata_i  (mem_rdata_i),
        .offset_i (req_q.off),
        .fmt_i    (req_q.fmt),
        .extend_i (req_q.ext),
        .result_o (load_data)
    );

    // State, timeout counter, request latches and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
            rdata_q <= '0;
            mis_q   <= 1'b0;
            berr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            rdata_q <= rdata_d;
            mis_q   <= mis_d;
            berr_q  <= berr_d;
        end
    end

    // Next-state logic; result registers default to 0 so they pulse only in DONE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        rdata_d = '0;
        mis_d   = 1'b0;
        berr_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (access) begin
                    if (is_misaligned(fmt_in, ALU_outM_i[1:0])) begin
                        state_d = DONE;
                        mis_d   = 1'b1;
                    end else begin
                        state_d     = REQ;
                        cnt_d       = '0;
                        req_d.addr  = {ALU_outM_i[DATA_BUS-1:2], 2'b00};
                        req_d.off   = ALU_outM_i[1:0];
                        req_d.be    = be_gen(fmt_in, ALU_outM_i[1:0]);
                        req_d.wdata = wdata_gen(fmt_in, WriteDataM_i);
                        req_d.we    = MemWriteM_i;
                        req_d.fmt   = fmt_in;
                        req_d.ext   = MemExtendM_i;
                    end
                end
            end
            REQ: begin
                // An ack on the final counted cycle still wins over the timeout.
                if (mem_ack_i) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    if (!req_q.we) begin
                        rdata_d = load_data;
                    end
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    berr_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                // Pipeline advances on this edge; never re-issue the same access.
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Reset gates the stall so the pipeline is released the moment rst rises.
    assign StallM_o    = access & (state_q != DONE) & ~rst;

    assign ReadDataM_o = rdata_q;
    assign MisalignM_o = mis_q;
    assign BusErrM_o   = berr_q;

    assign mem_req_o   = in_req;
    assign mem_we_o    = in_req & req_q.we;
    assign mem_addr_o  = in_req ? req_q.addr  : '0;
    assign mem_be_o    = in_req ? req_q.be    : '0;
    assign mem_wdata_o = in_req ? req_q.wdata : '0;

endmodule

// File: tb/tb_memory_access_unit.sv
// Randomized self-checking bench for memory_access_unit with a per-access
// reference model computed from byte arithmetic.
module tb_memory_access_unit;

    localparam int unsigned TIMEOUT = 16;

    logic        clk;
    logic        rst;
    logic        ValidM_i;
    logic [31:0] ALU_outM_i;
    logic [31:0] WriteDataM_i;
    logic        MemWriteM_i;
    logic        ResultSrcM_i;
    logic [1:0]  ByteSelectM_i;
    logic        MemExtendM_i;
    logic        StallM_o;
    logic [31:0] ReadDataM_o;
    logic        MisalignM_o;
    logic        BusErrM_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;

    int n_cmp = 0;
    int n_err = 0;

    memory_access_unit #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk           (clk),
        .rst           (rst),
        .ValidM_i      (ValidM_i),
        .ALU_outM_i    (ALU_outM_i),
        .WriteDataM_i  (WriteDataM_i),
        .MemWriteM_i   (MemWriteM_i),
        .ResultSrcM_i  (ResultSrcM_i),
        .ByteSelectM_i (ByteSelectM_i),
        .MemExtendM_i  (MemExtendM_i),
        .StallM_o      (StallM_o),
        .ReadDataM_o   (ReadDataM_o),
        .MisalignM_o   (MisalignM_o),
        .BusErrM_o     (BusErrM_o),
        .mem_req_o     (mem_req_o),
        .mem_we_o      (mem_we_o),
        .mem_addr_o    (mem_addr_o),
        .mem_be_o      (mem_be_o),
        .mem_wdata_o   (mem_wdata_o),
        .mem_ack_i     (mem_ack_i),
        .mem_rdata_i   (mem_rdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Expected load value: pick byte/half at offset k and extend arithmetically.
    function automatic logic [31:0] model_load(input logic [31:0] rd, input logic [31:0] addr,
                                               input int fmt, input logic ext);
        int unsigned k;
        logic [31:0] s;
        logic [31:0] v;
        k = addr % 4;
        s = rd >> (8 * k);
        if (fmt == 0) begin
            v = s & 32'hFF;
            if (ext && v >= 32'h80) v = v + 32'hFFFF_FF00;
        end else if (fmt == 1) begin
            v = s & 32'hFFFF;
            if (ext && v >= 32'h8000) v = v + 32'hFFFF_0000;
        end else begin
            v = rd;
        end
        return v;
    endfunction

    // One MEMORY-stage slot: IDLE cycle, REQ cycles (ack on cycle ack_after, 0 = never), DONE.
    task automatic run_op(input logic v, input logic wr, input logic ld,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input int fmt, input logic ext, input int ack_after,
                          input logic [31:0] rd);
        logic        acc, mis, berr;
        int unsigned k;
        logic [31:0] exp_be, exp_wd, exp_rd;
        int          n;
        logic        ack;
        logic        fin;

        k      = addr % 4;
        acc    = v && (wr || ld);
        mis    = (fmt == 1 && (k % 2) != 0) || (fmt == 2 && k != 0);
        berr   = !mis && (ack_after < 1 || ack_after > int'(TIMEOUT));
        exp_be = (fmt == 0) ? (32'd1 << k) : (fmt == 1) ? (32'd3 << k) : 32'd15;
        exp_wd = (fmt == 0) ? (wd % 256) * 32'h0101_0101 :
                 (fmt == 1) ? (wd % 65536) * 32'h0001_0001 : wd;
        exp_rd = (mis || berr || wr) ? 32'd0 : model_load(rd, addr, fmt, ext);

        @(posedge clk); #1;
        ValidM_i      = v;
        MemWriteM_i   = wr;
        ResultSrcM_i  = ld;
        ALU_outM_i    = addr;
        WriteDataM_i  = wd;
        ByteSelectM_i = 2'(fmt);
        MemExtendM_i  = ext;
        mem_ack_i     = 1'($urandom_range(0, 1));
        mem_rdata_i   = $urandom;
        @(negedge clk);
        check("idle_stall", StallM_o, acc);
        check("idle_req", mem_req_o, 0);
        if (!acc) begin
            check("idle_mis", MisalignM_o, 0);
            check("idle_berr", BusErrM_o, 0);
            check("idle_rdata", ReadDataM_o, 0);
            return;
        end

        if (!mis) begin
            n   = 0;
            fin = 1'b0;
            while (!fin) begin
                n++;
                @(posedge clk); #1;
                ack          = (n == ack_after);
                mem_ack_i    = ack;
                mem_rdata_i  = ack ? rd : $urandom;
                // Live operands change under the request; the latched copy must be used.
                ALU_outM_i    = $urandom;
                WriteDataM_i  = $urandom;
                ByteSelectM_i = 2'($urandom_range(0, 2));
                MemExtendM_i  = 1'($urandom_range(0, 1));
                @(negedge clk);
                check("req", mem_req_o, 1);
                check("req_stall", StallM_o, 1);
                check("req_we", mem_we_o, wr);
                check("req_addr", mem_addr_o, addr & 32'hFFFF_FFFC);
                check("req_be", mem_be_o, exp_be);
                check("req_wdata", mem_wdata_o, exp_wd);
                if (ack || n == int'(TIMEOUT)) fin = 1'b1;
            end
        end

        @(posedge clk); #1;
        mem_ack_i   = 1'b0;
        mem_rdata_i = $urandom;
        @(negedge clk);
        check("done_stall", StallM_o, 0);
        check("done_req", mem_req_o, 0);
        check("done_mis", MisalignM_o, mis);
        check("done_berr", BusErrM_o, berr);
        check("done_rdata", ReadDataM_o, exp_rd);
    endtask

    initial begin
        rst           = 1'b1;
        ValidM_i      = 1'b1;
        ALU_outM_i    = 32'h0;
        WriteDataM_i  = 32'h0;
        MemWriteM_i   = 1'b1;
        ResultSrcM_i  = 1'b0;
        ByteSelectM_i = 2'd2;
        MemExtendM_i  = 1'b0;
        mem_ack_i     = 1'b0;
        mem_rdata_i   = 32'h0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_stall", StallM_o, 0);
        check("rst_req", mem_req_o, 0);
        check("rst_rdata", ReadDataM_o, 0);
        check("rst_mis", MisalignM_o, 0);
        check("rst_berr", BusErrM_o, 0);
        ValidM_i = 1'b0;
        #1 rst = 1'b0;

        // Directed cases.
        run_op(1, 1, 0, 32'h100, 32'hDEAD_BEEF, 2, 0, 2, 32'h0);
        run_op(1, 1, 0, 32'h103, 32'h0000_00A5, 0, 0, 1, 32'h0);
        run_op(1, 0, 1, 32'h102, 32'h0, 0, 1, 1, 32'h1280_FF00);
        run_op(1, 0, 1, 32'h102, 32'h0, 1, 0, 3, 32'h1280_FF00);
        run_op(1, 0, 1, 32'h101, 32'h0, 2, 0, 1, 32'h0);
        run_op(1, 0, 1, 32'h200, 32'h0, 2, 0, 0, 32'h0);
        run_op(1, 0, 1, 32'h204, 32'h0, 2, 0, 16, 32'hCAFE_F00D);
        run_op(1, 1, 1, 32'h208, 32'h1234_5678, 2, 0, 1, 32'hFFFF_FFFF);
        run_op(0, 1, 1, 32'h20C, 32'h0, 2, 0, 1, 32'h0);

        // Reset while a load waits in REQ.
        @(posedge clk); #1;
        ValidM_i      = 1'b1;
        MemWriteM_i   = 1'b0;
        ResultSrcM_i  = 1'b1;
        ALU_outM_i    = 32'h300;
        ByteSelectM_i = 2'd2;
        mem_ack_i     = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("pre_rst_req", mem_req_o, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_req", mem_req_o, 0);
        check("mid_rst_stall", StallM_o, 0);
        ValidM_i = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        run_op(1, 0, 1, 32'h301, 32'h0, 0, 1, 1, 32'h0000_8000);

        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            logic [31:0] a;
            int          ackn;
            a    = $urandom;
            ackn = $urandom_range(1, 19);
            if (ackn > 17) ackn = 0;
            run_op(1'($urandom_range(0, 5) != 0), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), a, $urandom, $urandom_range(0, 2),
                   1'($urandom_range(0, 1)), ackn, $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
